// File: rtl/simple_circuit_3.sv
// simple_circuit_3: (A2 & B2) | C2 through a LATENCY-deep register pipeline
module simple_circuit_3 #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A2,
  input  logic B2,
  input  logic C2,
  output logic Z
);
  logic [LATENCY-1:0] stg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stg <= '0;
    else begin
      stg[0] <= (A2 & B2) | C2;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  assign Z = stg[LATENCY-1];
endmodule

// File: tb/tb_simple_circuit_3.sv
// tb_simple_circuit_3: LATENCY=1 and LATENCY=3 instances against a truth-table/queue model
module tb_simple_circuit_3;
  logic clk = 0, rst_n = 1, a = 0, b = 0, c = 0;
  logic z1, z3;
  int errors = 0, checks = 0;
  logic [7:0] tt = 8'b11101010;
  logic hist[$];

  simple_circuit_3 #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .A2(a), .B2(b), .C2(c), .Z(z1));
  simple_circuit_3 #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .A2(a), .B2(b), .C2(c), .Z(z3));

  always #5 clk = ~clk;

  // newest sample at the front; output of an L-deep pipe is entry L-1
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hist.delete();
    else begin
      hist.push_front(tt[{a, b, c}]);
      if (hist.size() > 8) void'(hist.pop_back());
    end

  function automatic logic expz(input int l);
    return (hist.size() >= l) ? hist[l-1] : 1'b0;
  endfunction

  task automatic test_reset;
    #1 rst_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 2;
      if (z1 !== 1'b0) begin errors++; $display("FAIL reset_hold z1: got %b want 0", z1); end
      if (z3 !== 1'b0) begin errors++; $display("FAIL reset_hold z3: got %b want 0", z3); end
      {a, b, c} = 3'b111 ^ 3'($urandom_range(0, 7));
    end
    {a, b, c} = 3'b111;
    rst_n = 1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1 checks += 2;
    if (z1 !== 1'b0) begin errors++; $display("FAIL reset_async z1: got %b want 0", z1); end
    if (z3 !== 1'b0) begin errors++; $display("FAIL reset_async z3: got %b want 0", z3); end
    @(negedge clk);
    {a, b, c} = 3'b000;
    rst_n = 1;
  endtask

  task automatic test_sweep;
    logic [2:0] abc;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      @(negedge clk);
      {a, b, c} = abc;
      @(negedge clk);
      checks += 2;
      if (z1 !== tt[abc]) begin errors++; $display("FAIL sweep abc=%b: got %b want %b", abc, z1, tt[abc]); end
      if (z3 !== expz(3)) begin errors++; $display("FAIL sweep_l3 abc=%b: got %b want %b", abc, z3, expz(3)); end
    end
  endtask

  task automatic test_pulse;
    @(negedge clk);
    {a, b, c} = 3'b000;
    repeat (4) @(negedge clk);
    c = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      c = 0;
      checks += 2;
      if (z3 !== logic'(k == 3)) begin errors++; $display("FAIL pulse k=%0d: got %b want %b", k, z3, k == 3); end
      if (z1 !== logic'(k == 1)) begin errors++; $display("FAIL pulse_l1 k=%0d: got %b want %b", k, z1, k == 1); end
    end
  endtask

  task automatic test_midreset;
    @(negedge clk);
    {a, b, c} = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    {a, b, c} = 3'b000;
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks += 2;
      if (z3 !== 1'b0) begin errors++; $display("FAIL midreset k=%0d: got %b want 0", k, z3); end
      if (z1 !== 1'b0) begin errors++; $display("FAIL midreset_l1 k=%0d: got %b want 0", k, z1); end
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    {a, b, c} = 3'b110;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks += 1;
      if (z1 !== 1'b1) begin errors++; $display("FAIL hold_l1 k=%0d: got %b want 1", k, z1); end
      if (k >= 3) begin
        checks += 1;
        if (z3 !== 1'b1) begin errors++; $display("FAIL hold_l3 k=%0d: got %b want 1", k, z3); end
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      checks += 2;
      if (z1 !== expz(1)) begin errors++; $display("FAIL random_l1 k=%0d: got %b want %b", k, z1, expz(1)); end
      if (z3 !== expz(3)) begin errors++; $display("FAIL random_l3 k=%0d: got %b want %b", k, z3, expz(3)); end
      {a, b, c} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 0;
        #2 checks += 2;
        if (z1 !== 1'b0) begin errors++; $display("FAIL random_rst z1 k=%0d: got %b want 0", k, z1); end
        if (z3 !== 1'b0) begin errors++; $display("FAIL random_rst z3 k=%0d: got %b want 0", k, z3); end
        rst_n = 1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_pulse;
    test_midreset;
    test_hold;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
